flag_set_reg: RTL and testbench
===============================

Name: flag_set_reg

Overview:
- Parametrised successor to the 4-bit set/clear state register: a WIDTH-bit flag register where single bits are set, cleared or toggled by an indexed command.
- Adds a valid/ready command handshake, a bulk clear, an out-of-range error, a registered population count and any/all summaries.
- Sits between control decoders (switch/button front-ends) and display/status logic.

Parameters:
- WIDTH, 16, number of flag bits (2..64).
- IDX_W, $clog2(WIDTH), width of cmd_idx.
- CNT_W, $clog2(WIDTH+1), width of count.
- HOLD, 8, auto-clear hold time in clk cycles (used only with the optional feature; 1..255).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- en  in  1  global enable; when low, no command is accepted and no timer advances.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command can be accepted; combinational, equals en.
- cmd_op  in  2  0=CLEAR bit, 1=SET bit, 2=TOGGLE bit, 3=CLEAR_ALL (cmd_idx ignored).
- cmd_idx  in  IDX_W  target bit.
- err_clr  in  1  clears err.
- flags  out  WIDTH  current flag state.
- count  out  CNT_W  number of set flags.
- any  out  1  at least one flag set.
- all  out  1  every flag set.
- changed  out  1  single-cycle pulse when flags changed value.
- err  out  1  sticky out-of-range error.

Behaviour:
- Reset (rst high at posedge clk; takes priority over every input): flags=0, count=0, any=0, all=0, changed=0, err=0, hold timers=0.
- Accept: a command is accepted when cmd_valid && cmd_ready at posedge clk. The bus has no buffering; an unaccepted command is simply not applied.
- Command latency: flags update at the posedge that accepts the command (visible the following cycle).
- Valid index (cmd_idx < WIDTH):
  - CLEAR: flags[idx] <= 0.
  - SET: flags[idx] <= 1.
  - TOGGLE: flags[idx] <= ~flags[idx].
  - Operations on a bit already in the target state are legal no-ops.
- Out-of-range index: cmd_idx >= WIDTH with op 0..2 leaves flags unchanged and sets err. CLEAR_ALL never raises err.
- CLEAR_ALL: flags <= 0.
- err clearing: err is cleared by err_clr. If an error event and err_clr occur in the same cycle, err stays 1 (the error wins).
- changed: asserted one cycle after any posedge at which flags took a new value, from a command or from an auto-clear. It is registered and is 0 if flags did not change.
- count, any, all: registered from the updated flags, so they are valid one cycle after flags (two cycles after acceptance). They are combinational from flags, then registered.
- en low: cmd_ready=0, flags hold, summaries keep tracking flags.
- Reset mid-stream: a command presented in the same cycle as rst is discarded.

Optional Feature:
- Macro: FLAG_SET_REG_AUTOCLR_EN.
- When defined:
  - Each bit has an 8-bit down-counter, loaded with HOLD whenever the bit is set by SET or by TOGGLE 0->1.
  - The counter decrements each en-high cycle while the bit is 1. When it reaches 1, the bit clears at the next posedge, so a bit stays high for exactly HOLD enabled cycles.
  - SET on an already-set bit reloads the timer (retrigger).
  - CLEAR, TOGGLE 1->0 and CLEAR_ALL zero the timer.
  - A command and an expiry on the same bit in the same cycle: the command wins.
- When undefined: no timers exist and bits persist until cleared.

Decomposition:
- Package flag_set_pkg holds:
  - typedef enum logic [1:0] flag_op_e {OP_CLR, OP_SET, OP_TGL, OP_CLR_ALL};
  - localparam HOLD_W = 8.
- One natural sub-module, flag_popcount: a combinational WIDTH-bit population count with any/all, instantiated once. Its outputs are registered in flag_set_reg.
- The per-bit timer is a generate loop inside the top module, not a separate module.

Test Plan:
- Reset, then SET idx 0, 1, 3 on consecutive cycles -> flags=16'h000B, count=3 two cycles after the last accept, changed pulses 3 times, any=1, all=0.
- TOGGLE idx 3 twice, then CLEAR idx 0 on flags=16'h000B -> flags 16'h0003, then 16'h000B, then 16'h000A; SET idx 1 (no-op) -> changed stays 0.
- WIDTH=12, SET idx 13 -> flags unchanged, err=1; err_clr together with another bad index -> err stays 1; err_clr alone -> err=0.
- SET all 16 bits, then CLEAR_ALL -> all=1 and count=16, then flags=0, count=0, any=0, single changed pulse.
- en=0 with cmd_valid=1 SET idx 5 -> cmd_ready=0, flags unchanged; rst asserted together with a valid command -> flags=0 and the command is dropped.
- With FLAG_SET_REG_AUTOCLR_EN and HOLD=4: SET idx 2 -> bit high for exactly 4 cycles; re-SET at cycle 2 -> bit high until 4 cycles after the re-SET; en=0 for 3 cycles freezes the timer.

Source files
------------

// File: rtl/flag_set_pkg.sv
`default_nettype none
// ============================================================================
// Module      : flag_set_pkg
// Description : Shared types and constants for the flag_set_reg block.
// Revision    : 1.0 - initial release
// ============================================================================
package flag_set_pkg;

    typedef enum logic [1:0] {
        OP_CLR     = 2'd0,
        OP_SET     = 2'd1,
        OP_TGL     = 2'd2,
        OP_CLR_ALL = 2'd3
    } flag_op_e;

    localparam int HOLD_W = 8;

endpackage
`default_nettype wire

// File: rtl/flag_popcount.sv
`default_nettype none
// ============================================================================
// Module      : flag_popcount
// Description : Combinational population count with any/all summaries.
// Revision    : 1.0 - initial release
// ============================================================================
module flag_popcount #(
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] flags,
    output logic [CNT_W-1:0] count,
    output logic             any,
    output logic             all
);

    always_comb begin
        count = '0;
        for (int i = 0; i < WIDTH; i++) begin
            count = count + CNT_W'(flags[i]);
        end
    end

    assign any = |flags;
    assign all = &flags;

endmodule
`default_nettype wire

// File: rtl/flag_set_reg.sv
`default_nettype none
// ============================================================================
// Module      : flag_set_reg
// Description : WIDTH-bit indexed set/clear/toggle flag register with
//               handshake, sticky range error and registered summaries.
//               Define FLAG_SET_REG_AUTOCLR_EN for per-bit auto-clear timers.
// Revision    : 1.0 - initial release
// ============================================================================
module flag_set_reg
    import flag_set_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int IDX_W = $clog2(WIDTH),
    parameter int CNT_W = $clog2(WIDTH + 1),
    parameter int HOLD  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [IDX_W-1:0] cmd_idx,
    input  logic             err_clr,
    output logic [WIDTH-1:0] flags,
    output logic [CNT_W-1:0] count,
    output logic             any,
    output logic             all,
    output logic             changed,
    output logic             err
);

    flag_op_e         w_op;
    logic             w_acc;
    logic             w_in_range;
    logic             w_clr_all;
    logic             w_bit_cmd;
    logic             w_err_evt;
    logic [WIDTH-1:0] w_flags_nxt;
    logic [CNT_W-1:0] w_count;
    logic             w_any;
    logic             w_all;

    logic [WIDTH-1:0] r_flags;
    logic [CNT_W-1:0] r_count;
    logic             r_any;
    logic             r_all;
    logic             r_changed;
    logic             r_err;

    assign w_op      = flag_op_e'(cmd_op);
    assign cmd_ready = en;
    assign w_acc     = cmd_valid & en;

    // A power-of-two width cannot be addressed out of range.
    if (2 ** IDX_W == WIDTH) begin : g_range_full
        assign w_in_range = 1'b1;
    end else begin : g_range_part
        assign w_in_range = ({1'b0, cmd_idx} < (IDX_W + 1)'(WIDTH));
    end

    assign w_clr_all = w_acc & (w_op == OP_CLR_ALL);
    assign w_bit_cmd = w_acc & (w_op != OP_CLR_ALL) & w_in_range;
    assign w_err_evt = w_acc & (w_op != OP_CLR_ALL) & ~w_in_range;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic w_hit;
        logic w_nxt;

        assign w_hit          = w_bit_cmd && (cmd_idx == IDX_W'(i));
        assign w_flags_nxt[i] = w_nxt;

`ifdef FLAG_SET_REG_AUTOCLR_EN
        logic [HOLD_W-1:0] r_tmr;
        logic [HOLD_W-1:0] w_tmr_nxt;

        // Commands take priority over expiry on the same bit.
        always_comb begin
            w_nxt     = r_flags[i];
            w_tmr_nxt = r_tmr;
            if (w_clr_all) begin
                w_nxt     = 1'b0;
                w_tmr_nxt = '0;
            end else if (w_hit) begin
                case (w_op)
                    OP_SET: begin
                        w_nxt     = 1'b1;
                        w_tmr_nxt = HOLD_W'(HOLD);
                    end
                    OP_TGL: begin
                        w_nxt     = ~r_flags[i];
                        w_tmr_nxt = r_flags[i] ? '0 : HOLD_W'(HOLD);
                    end
                    default: begin
                        w_nxt     = 1'b0;
                        w_tmr_nxt = '0;
                    end
                endcase
            end else if (en && r_flags[i] && (r_tmr != '0)) begin
                w_tmr_nxt = r_tmr - HOLD_W'(1);
                if (r_tmr == HOLD_W'(1)) begin
                    w_nxt = 1'b0;
                end
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                r_tmr <= '0;
            end else begin
                r_tmr <= w_tmr_nxt;
            end
        end
`else
        always_comb begin
            w_nxt = r_flags[i];
            if (w_clr_all) begin
                w_nxt = 1'b0;
            end else if (w_hit) begin
                case (w_op)
                    OP_SET:  w_nxt = 1'b1;
                    OP_TGL:  w_nxt = ~r_flags[i];
                    default: w_nxt = 1'b0;
                endcase
            end
        end
`endif
    end

`ifndef FLAG_SET_REG_AUTOCLR_EN
    logic w_unused_hold;
    assign w_unused_hold = ^(HOLD_W'(HOLD));
`endif

    flag_popcount #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_popcount (
        .flags (r_flags),
        .count (w_count),
        .any   (w_any),
        .all   (w_all)
    );

    // A new error in the same cycle as err_clr keeps err set.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_flags   <= '0;
            r_count   <= '0;
            r_any     <= 1'b0;
            r_all     <= 1'b0;
            r_changed <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_flags   <= w_flags_nxt;
            r_count   <= w_count;
            r_any     <= w_any;
            r_all     <= w_all;
            r_changed <= (w_flags_nxt != r_flags);
            r_err     <= w_err_evt | (r_err & ~err_clr);
        end
    end

    assign flags   = r_flags;
    assign count   = r_count;
    assign any     = r_any;
    assign all     = r_all;
    assign changed = r_changed;
    assign err     = r_err;

endmodule
`default_nettype wire

// File: tb/tb_flag_set_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_flag_set_reg
// Description : Directed self-checking bench for flag_set_reg (WIDTH 16 and 12).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_flag_set_reg;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // WIDTH=16 instance
    logic        en, cmd_valid, err_clr, cmd_ready;
    logic [1:0]  cmd_op;
    logic [3:0]  cmd_idx;
    logic [15:0] flags;
    logic [4:0]  count;
    logic        any, all, changed, err;

    // WIDTH=12 instance
    logic        en12, cmd_valid12, err_clr12, cmd_ready12;
    logic [1:0]  cmd_op12;
    logic [3:0]  cmd_idx12;
    logic [11:0] flags12;
    logic [3:0]  count12;
    logic        any12, all12, changed12, err12;

    int checks   = 0;
    int failures = 0;
    int pulses;
    int hi;

    flag_set_reg #(.WIDTH(16), .HOLD(4)) u_dut16 (
        .clk(clk), .rst(rst), .en(en), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_idx(cmd_idx), .err_clr(err_clr), .flags(flags),
        .count(count), .any(any), .all(all), .changed(changed), .err(err)
    );

    flag_set_reg #(.WIDTH(12), .HOLD(4)) u_dut12 (
        .clk(clk), .rst(rst), .en(en12), .cmd_valid(cmd_valid12), .cmd_ready(cmd_ready12),
        .cmd_op(cmd_op12), .cmd_idx(cmd_idx12), .err_clr(err_clr12), .flags(flags12),
        .count(count12), .any(any12), .all(all12), .changed(changed12), .err(err12)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic cmd16(input logic [1:0] o, input int i);
        cmd_valid = 1'b1;
        cmd_op    = o;
        cmd_idx   = 4'(i);
        tick(1);
        cmd_valid = 1'b0;
    endtask

    task automatic cmd12(input logic [1:0] o, input int i, input logic clr);
        cmd_valid12 = 1'b1;
        cmd_op12    = o;
        cmd_idx12   = 4'(i);
        err_clr12   = clr;
        tick(1);
        cmd_valid12 = 1'b0;
        err_clr12   = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; cmd_valid = 1'b0; err_clr = 1'b0; cmd_op = 2'd0; cmd_idx = '0;
        en12 = 1'b1; cmd_valid12 = 1'b0; err_clr12 = 1'b0; cmd_op12 = 2'd0; cmd_idx12 = '0;
        #1;
        do_reset();

        check("rst_flags", 64'(flags), 64'h0);
        check("rst_count", 64'(count), 64'd0);
        check("rst_any", 64'(any), 64'd0);
        check("rst_all", 64'(all), 64'd0);
        check("rst_changed", 64'(changed), 64'd0);
        check("rst_err", 64'(err), 64'd0);

        // SET 0, 1, 3 back to back
        pulses = 0;
        cmd16(2'd1, 0); pulses += int'(changed);
        cmd16(2'd1, 1); pulses += int'(changed);
        cmd16(2'd1, 3); pulses += int'(changed);
        check("set_flags", 64'(flags), 64'h000B);
        check("set_count_lag", 64'(count), 64'd2);
        tick(1); pulses += int'(changed);
        check("set_count", 64'(count), 64'd3);
        check("set_any", 64'(any), 64'd1);
        check("set_all", 64'(all), 64'd0);
        check("set_pulses", 64'(pulses), 64'd3);

        // Toggle/clear sequence and a no-op SET
        cmd16(2'd2, 3);
        check("tgl1_flags", 64'(flags), 64'h0003);
        cmd16(2'd2, 3);
        check("tgl2_flags", 64'(flags), 64'h000B);
        cmd16(2'd0, 0);
        check("clr0_flags", 64'(flags), 64'h000A);
        check("clr0_changed", 64'(changed), 64'd1);
        cmd16(2'd1, 1);
        check("noop_flags", 64'(flags), 64'h000A);
        check("noop_changed", 64'(changed), 64'd0);

        // Fill all bits then bulk clear
        for (int i = 0; i < 16; i++) cmd16(2'd1, i);
        tick(1);
        check("full_flags", 64'(flags), 64'hFFFF);
        check("full_all", 64'(all), 64'd1);
        check("full_count", 64'(count), 64'd16);
        pulses = 0;
        cmd16(2'd3, 9); pulses += int'(changed);
        check("clrall_flags", 64'(flags), 64'h0);
        check("clrall_err", 64'(err), 64'd0);
        tick(1); pulses += int'(changed);
        tick(1); pulses += int'(changed);
        check("clrall_count", 64'(count), 64'd0);
        check("clrall_any", 64'(any), 64'd0);
        check("clrall_all", 64'(all), 64'd0);
        check("clrall_pulses", 64'(pulses), 64'd1);

        // Disabled: command not accepted
        en = 1'b0;
        cmd_valid = 1'b1; cmd_op = 2'd1; cmd_idx = 4'd5;
        #1;
        check("dis_ready", 64'(cmd_ready), 64'd0);
        tick(1);
        cmd_valid = 1'b0;
        check("dis_flags", 64'(flags), 64'h0);
        en = 1'b1;
        #1;
        check("en_ready", 64'(cmd_ready), 64'd1);

        // Reset together with a valid command
        cmd16(2'd1, 2);
        check("pre_rst_flags", 64'(flags), 64'h0004);
        rst = 1'b1; cmd_valid = 1'b1; cmd_op = 2'd1; cmd_idx = 4'd7;
        tick(1);
        rst = 1'b0; cmd_valid = 1'b0;
        check("rstcmd_flags", 64'(flags), 64'h0);
        tick(1);
        check("rstcmd_hold", 64'(flags), 64'h0);

        // WIDTH=12 range errors
        cmd12(2'd1, 4, 1'b0);
        cmd12(2'd1, 11, 1'b0);
        check("w12_edge_flags", 64'(flags12), 64'h810);
        cmd12(2'd1, 13, 1'b0);
        check("w12_bad_flags", 64'(flags12), 64'h810);
        check("w12_bad_err", 64'(err12), 64'd1);
        cmd12(2'd2, 14, 1'b1);
        check("w12_errwins", 64'(err12), 64'd1);
        check("w12_errwins_flags", 64'(flags12), 64'h810);
        err_clr12 = 1'b1;
        tick(1);
        err_clr12 = 1'b0;
        check("w12_errclr", 64'(err12), 64'd0);
        cmd12(2'd3, 15, 1'b0);
        check("w12_clrall_err", 64'(err12), 64'd0);
        check("w12_clrall_flags", 64'(flags12), 64'h0);
        cmd12(2'd1, 12, 1'b0);
        check("w12_idx12_err", 64'(err12), 64'd1);

`ifdef FLAG_SET_REG_AUTOCLR_EN
        do_reset();
        cmd16(2'd1, 2);
        hi = 0;
        for (int k = 0; k < 10; k++) begin
            if (flags[2]) hi++;
            tick(1);
        end
        check("ac_hold", 64'(hi), 64'd4);

        do_reset();
        cmd16(2'd1, 2);
        tick(1);
        cmd16(2'd1, 2);
        hi = 0;
        for (int k = 0; k < 10; k++) begin
            if (flags[2]) hi++;
            tick(1);
        end
        check("ac_retrig", 64'(hi), 64'd4);

        do_reset();
        cmd16(2'd1, 2);
        hi = 0;
        for (int k = 0; k < 12; k++) begin
            if (flags[2]) hi++;
            en = !(k >= 1 && k <= 3);
            tick(1);
        end
        en = 1'b1;
        check("ac_freeze", 64'(hi), 64'd7);
`else
        do_reset();
        cmd16(2'd1, 2);
        tick(10);
        check("persist_flags", 64'(flags), 64'h0004);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
